// File: rtl/vga_scan_controller_if.sv
// Scan-controller signal bundle.
//   EN    : scan enable, driven by the master
//   HCNT  : horizontal pixel counter (0..H_TOTAL-1)
//   VCNT  : vertical line counter (0..V_TOTAL-1)
//   HS/VS : active-low horizontal/vertical sync
//   VID   : active-video flag
//   BAR   : colour-bar index 0..7
//   FRAME : one-CLK pulse on the first pixel of each frame
//   PIXEN : pixel-advance strobe
// Modports: master drives EN and observes timing; slave is the controller.
interface vga_scan_controller_if;
  logic       EN;
  logic [9:0] HCNT;
  logic [9:0] VCNT;
  logic       HS;
  logic       VS;
  logic       VID;
  logic [2:0] BAR;
  logic       FRAME;
  logic       PIXEN;

  modport master (
    output EN,
    input  HCNT, VCNT, HS, VS, VID, BAR, FRAME, PIXEN
  );

  modport slave (
    input  EN,
    output HCNT, VCNT, HS, VS, VID, BAR, FRAME, PIXEN
  );
endinterface

// File: rtl/vga_scan_controller.sv
// 640x480@60 scan-timing controller.
// Generates horizontal/vertical counters, active-low syncs, the active-video
// flag, a registered colour-bar index, a frame-start pulse and a pixel strobe.
// Ports:
//   CLK : system clock
//   RST : synchronous reset, active-high
//   bus : vga_scan_controller_if.slave (EN in; HCNT, VCNT, HS, VS, VID, BAR,
//         FRAME, PIXEN out). Every output is a flop.
// Configuration:
//   VGA_PIXEL_DIV2_EN defined   -> pixels advance every second CLK (PIXEN toggles)
//   VGA_PIXEL_DIV2_EN undefined -> pixels advance every RUN CLK
module vga_scan_controller #(
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_TOTAL = 525
) (
  input logic                         CLK,
  input logic                         RST,
  vga_scan_controller_if.slave        bus
);

  localparam logic [9:0] HLast     = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast     = 10'(V_TOTAL - 1);
  localparam logic [9:0] HSyncEnd  = 10'd96;
  localparam logic [9:0] HActStart = 10'd144;
  localparam logic [9:0] HActEnd   = 10'd784;
  localparam logic [9:0] VSyncEnd  = 10'd2;
  localparam logic [9:0] VActStart = 10'd35;
  localparam logic [9:0] VActEnd   = 10'd515;
  localparam logic [9:0] BarClear  = 10'd783;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e     state_q, state_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       vid_q, vid_d;
  logic [2:0] bar_q, bar_d;
  logic       frame_q, frame_d;
  logic       pixen_q, pixen_d;
  logic       adv;
  logic       run_d;

`ifdef VGA_PIXEL_DIV2_EN
  logic tog_q, tog_d;
`endif

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    bar_d   = bar_q;
    frame_d = 1'b0;
    adv     = 1'b0;
`ifdef VGA_PIXEL_DIV2_EN
    tog_d   = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        hcnt_d = '0;
        vcnt_d = '0;
        bar_d  = '0;
        if (bus.EN) begin
          state_d = StRun;
          frame_d = 1'b1;
        end
      end
      StRun: begin
        if (!bus.EN) begin
          // Immediate abort: back to idle values, no end-of-frame wait.
          state_d = StIdle;
          hcnt_d  = '0;
          vcnt_d  = '0;
          bar_d   = '0;
        end else begin
`ifdef VGA_PIXEL_DIV2_EN
          // Counters move on the second CLK of each pixel.
          tog_d = ~tog_q;
          adv   = tog_q;
`else
          adv   = 1'b1;
`endif
          if (adv) begin
            if (hcnt_q == HLast) begin
              hcnt_d = '0;
              if (vcnt_q == VLast) begin
                vcnt_d  = '0;
                frame_d = 1'b1;
              end else begin
                vcnt_d = vcnt_q + 10'd1;
              end
            end else begin
              hcnt_d = hcnt_q + 10'd1;
            end
            // Bar index steps one pixel ahead of each 80-pixel boundary.
            case (hcnt_q)
              10'd223, 10'd303, 10'd383, 10'd463,
              10'd543, 10'd623, 10'd703: bar_d = bar_q + 3'd1;
              BarClear:                  bar_d = '0;
              default:                   bar_d = bar_q;
            endcase
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Decodes are taken from next-state counts so the registered outputs
    // line up with the counter values of the same cycle.
    run_d = (state_d == StRun);
    hs_d  = !(run_d && (hcnt_d < HSyncEnd));
    vs_d  = !(run_d && (vcnt_d < VSyncEnd));
    vid_d = run_d && (hcnt_d >= HActStart) && (hcnt_d < HActEnd) &&
            (vcnt_d >= VActStart) && (vcnt_d < VActEnd);
`ifdef VGA_PIXEL_DIV2_EN
    pixen_d = tog_d;
`else
    pixen_d = run_d;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      vid_q   <= 1'b0;
      bar_q   <= '0;
      frame_q <= 1'b0;
      pixen_q <= 1'b0;
`ifdef VGA_PIXEL_DIV2_EN
      tog_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      vid_q   <= vid_d;
      bar_q   <= bar_d;
      frame_q <= frame_d;
      pixen_q <= pixen_d;
`ifdef VGA_PIXEL_DIV2_EN
      tog_q   <= tog_d;
`endif
    end
  end

  assign bus.HCNT  = hcnt_q;
  assign bus.VCNT  = vcnt_q;
  assign bus.HS    = hs_q;
  assign bus.VS    = vs_q;
  assign bus.VID   = vid_q;
  assign bus.BAR   = bar_q;
  assign bus.FRAME = frame_q;
  assign bus.PIXEN = pixen_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Testbench for vga_scan_controller. A shortened frame (V_TOTAL=36) keeps the
// run short while still covering sync, active region, bars and frame wrap.
module tb_vga_scan_controller;

  localparam int HTot = 800;
  localparam int TbV  = 36;
`ifdef VGA_PIXEL_DIV2_EN
  localparam int Div = 2;
`else
  localparam int Div = 1;
`endif
  localparam int FrameClk = HTot * TbV * Div;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  vga_scan_controller_if bus ();

  vga_scan_controller #(
    .H_TOTAL(HTot),
    .V_TOTAL(TbV)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: running flag plus CLK count since the first RUN cycle.
  bit m_run = 1'b0;
  int m_t   = 0;

  // Frame-window statistics.
  int win_lo = -1;
  int win_hi = -2;
  int hs_low = 0;
  int vs_low = 0;
  int vid_hi = 0;
  int fr_n   = 0;
  int fr_at0 = -1;
  int fr_at1 = -1;
  bit rec_on = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int k, h, v;
    logic [27:0] got, exp;
    logic [9:0]  eh, ev;
    logic        ehs, evs, evid, efr, epx;
    logic [2:0]  ebar;
    k = m_t / Div;
    h = k % HTot;
    v = (k / HTot) % TbV;
    eh   = m_run ? 10'(h) : 10'd0;
    ev   = m_run ? 10'(v) : 10'd0;
    ehs  = !(m_run && h < 96);
    evs  = !(m_run && v < 2);
    evid = m_run && h >= 144 && h < 784 && v >= 35 && v < 515;
    ebar = (m_run && h >= 224 && h < 784) ? 3'((h - 144) / 80) : 3'd0;
    efr  = m_run && (k % (HTot * TbV) == 0) && (m_t % Div == 0);
    epx  = m_run && ((Div == 1) || (m_t % Div == 1));
    exp = {eh, ev, ehs, evs, evid, ebar, efr, epx};
    got = {bus.HCNT, bus.VCNT, bus.HS, bus.VS, bus.VID, bus.BAR, bus.FRAME, bus.PIXEN};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d {H,V,HS,VS,VID,BAR,FR,PX} observed=%h expected=%h",
             tag, cyc, got, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    cyc++;
    if (RST) begin
      m_run = 1'b0;
      m_t   = 0;
    end else if (!m_run && bus.EN) begin
      m_run = 1'b1;
      m_t   = 0;
    end else if (m_run && !bus.EN) begin
      m_run = 1'b0;
    end else if (m_run) begin
      m_t++;
    end
    @(negedge CLK);
    check_outputs(tag);
    if (cyc >= win_lo && cyc <= win_hi) begin
      if (bus.HS === 1'b0) hs_low++;
      if (bus.VS === 1'b0) vs_low++;
      if (bus.VID === 1'b1) vid_hi++;
    end
    if (rec_on && bus.FRAME === 1'b1) begin
      if (fr_n == 0) fr_at0 = cyc;
      if (fr_n == 1) fr_at1 = cyc;
      fr_n++;
    end
  endtask

  initial begin
    int base;
    bit found;

    bus.EN = 1'b0;
    RST    = 1'b1;

    // Reset holds idle values regardless of EN.
    for (int i = 0; i < 3; i++) begin
      bus.EN = 1'($urandom % 2);
      step("reset");
    end
    chk("reset_pixen", int'(bus.PIXEN), 0);
    chk("reset_hs", int'(bus.HS), 1);

    RST    = 1'b0;
    bus.EN = 1'b0;
    repeat (2 + $urandom % 4) step("idle");

    // One full frame plus the start of the next.
    base   = cyc;
    win_lo = base + 1;
    win_hi = base + FrameClk;
    rec_on = 1'b1;
    bus.EN = 1'b1;
    repeat (FrameClk + 900 * Div) step("frame");
    rec_on = 1'b0;

    chk("frame_first_at", fr_at0, base + 1);
    chk("frame_second_at", fr_at1, base + 1 + FrameClk);
    chk("frame_pulse_count", fr_n, 2);
    chk("hs_low_per_frame", hs_low, 96 * Div * TbV);
    chk("vs_low_per_frame", vs_low, 2 * HTot * Div);
    chk("vid_high_per_frame", vid_hi, 640 * Div * (TbV - 35));

    // Abort mid-line at HCNT=500.
    found = 1'b0;
    for (int i = 0; i < 2000 * Div && !found; i++) begin
      if (((m_t / Div) % HTot == 500) && (m_t % Div == 0)) found = 1'b1;
      else step("seek500");
    end
    chk("abort_reached", int'(found), 1);
    chk("abort_pre_hcnt", int'(bus.HCNT), 500);
    bus.EN = 1'b0;
    step("abort");
    chk("abort_hcnt", int'(bus.HCNT), 0);
    chk("abort_vs", int'(bus.VS), 1);
    chk("abort_vid", int'(bus.VID), 0);

    repeat (1 + $urandom % 5) step("abort_idle");
    bus.EN = 1'b1;
    step("restart");
    chk("restart_frame", int'(bus.FRAME), 1);
    repeat ($urandom_range(300, 1500)) step("restart_run");

    // Synchronous reset mid-line with EN held high.
    RST = 1'b1;
    step("rst_mid");
    chk("rst_mid_hcnt", int'(bus.HCNT), 0);
    chk("rst_mid_pixen", int'(bus.PIXEN), 0);
    RST = 1'b0;
    step("rst_release");
    chk("rst_release_frame", int'(bus.FRAME), 1);
    repeat ($urandom_range(50, 400)) step("rst_run");

    // Random EN / RST segments.
    for (int s = 0; s < 20; s++) begin
      bus.EN = 1'($urandom % 4 != 0);
      RST    = 1'($urandom % 8 == 0);
      repeat ($urandom_range(1, 200)) step("random");
    end
    RST = 1'b0;
    step("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_scan_controller.md
# vga_scan_controller

Scan-timing controller for the DE0-CV VGA path. It generates the 640x480@60 horizontal and vertical pixel counters, the active-low sync pulses, the active-video flag and the 3-bit colour-bar index, all from one clock. It sits between the board clock and the colour/pixel datapath, and is the single source of the horizontal count that bar-selection logic keys on.

## Interface
Parameters:
- H_TOTAL, 800, pixels per line (counter range 0..799)
- V_TOTAL, 525, lines per frame (counter range 0..524)

Ports:
- CLK  in  1  system clock. One clock; reset is synchronous and active-high.
- RST  in  1  synchronous reset, active-high
- EN  in  1  scan enable; low holds the block idle
- HCNT  out  10  horizontal pixel counter
- VCNT  out  10  vertical line counter
- HS  out  1  horizontal sync, active-low
- VS  out  1  vertical sync, active-low
- VID  out  1  active-video flag
- BAR  out  3  colour-bar index, 0..7
- FRAME  out  1  one-cycle pulse on the first pixel of each frame
- PIXEN  out  1  pixel-advance strobe

## Operation
- Two-state FSM: IDLE and RUN.
- IDLE:
  - HCNT=0, VCNT=0, HS=1, VS=1, VID=0, BAR=0, FRAME=0.
  - EN=1 moves the FSM to RUN on the next edge. In that first RUN cycle HCNT=0, VCNT=0 and FRAME=1.
- RUN:
  - On each pixel advance, HCNT increments.
  - At HCNT=799, HCNT wraps to 0 and VCNT increments.
  - At (799,524), both counters wrap to 0 and FRAME pulses.
- RUN, EN=0: next edge returns to IDLE with all IDLE values. This is an immediate abort, not an end-of-frame stop.
- RST=1 forces IDLE with IDLE values on the edge, regardless of state or EN.
- Decodes, evaluated in RUN and consistent with the HCNT/VCNT values present in the same cycle:
  - HS=0 when HCNT 0..95; back porch 96..143; active 144..783; front porch 784..799.
  - VS=0 when VCNT 0..1; back porch 2..34; active 35..514; front porch 515..524.
  - VID=1 only when HCNT is in 144..783 and VCNT is in 35..514.
  - BAR=0 for HCNT 0..223 and 784..799; otherwise BAR=(HCNT-144)/80.
  - BAR boundaries: 224→1, 304→2, 384→3, 464→4, 544→5, 624→6, 704→7, last 7 at 783.
- BAR is kept as a registered incrementing index, advanced at HCNT=223,303,…,703 and cleared at 783. No divider.
- Arithmetic: unsigned 10-bit counters; they never exceed 799/524.

## Timing
- All outputs registered; no combinational path from any input to any output.
- Latency:
  - EN rise to first RUN cycle: 1 CLK.
  - EN fall to IDLE outputs: 1 CLK.
- Without the divider, a line is 800 CLK and a frame is 420000 CLK.
- FRAME is high exactly one CLK per frame, in the cycle HCNT=0 and VCNT=0.
- With the divider, FRAME still lasts only one CLK: the first CLK of the pixel, not the held second CLK.
- Reset value of every output: HCNT=0, VCNT=0, HS=1, VS=1, VID=0, BAR=0, FRAME=0, PIXEN=0.

## Configuration
- Macro VGA_PIXEL_DIV2_EN.
- Defined:
  - An internal toggle, reset to 0 and cleared in IDLE, halves the pixel rate (50 MHz CLK → 25 MHz pixel).
  - Counters advance only in CLK cycles where the toggle is 1. PIXEN=1 in exactly those cycles.
  - All other outputs hold for 2 CLK per pixel. Line is 1600 CLK, frame 840000 CLK.
- Undefined:
  - Counters advance every RUN cycle.
  - PIXEN=1 throughout RUN, 0 in IDLE/reset.

## Test plan
- Reset then EN=1 for one full frame, no divider → FRAME high at CLK 1 and CLK 420001. HS low for 96 of every 800 CLK. VS low for exactly 1600 CLK. VID high for 307200 CLK per frame.
- Sweep one active line → BAR is 0 through HCNT 223, becomes 1 at 224, 7 at 704..783, and returns to 0 at 784. VID rises at HCNT 144 and falls at 784.
- Wrap check → after (799,34) comes (0,35) with VID still 0 until HCNT=144. After (799,524) comes (0,0) with FRAME=1.
- EN dropped at HCNT=500, VCNT=200 → next CLK: HCNT=0, VCNT=0, HS=VS=1, VID=0. EN re-raised → restarts at (0,0) with FRAME=1.
- RST asserted mid-line with EN=1 → next CLK all reset values. After RST release with EN still 1 → RUN begins 1 CLK later at (0,0).
- VGA_PIXEL_DIV2_EN defined → PIXEN alternates 0,1 starting at 0. HCNT steps every 2 CLK. HS low for 192 CLK per line. Frame is 840000 CLK.
